find_bkt_lvl_pipe: RTL

FIND_BKT_LVL_PIPE -- requirements
Module: find_bkt_lvl_pipe

---
 rtl/find_bkt_lvl_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/find_bkt_lvl_pipe.sv
// Descending level-state scan for the first level without a bucket, with optional mark write.
// First read 1 cycle after start; data valid RD_LATENCY cycles after each read; no backpressure.
module find_bkt_lvl_pipe #(
   parameter int WIDTH_LVL              = 16,
   parameter int WIDTH_BIN_ID           = 10,
   parameter int ADDR_WIDTH_LVLS_STATES = 9,
   parameter int RD_LATENCY             = 1,
   localparam int WIDTH_LVL_STATES      = WIDTH_BIN_ID + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_find,
   input  logic                              abort_i,
   input  logic                              mode_mark_i,
   input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
   input  logic [WIDTH_LVL-1:0]              lvl_floor_i,
   output logic                              busy_o,
   output logic                              apply_find_o,
   output logic                              done_find,
   output logic                              found_o,
   output logic [WIDTH_LVL-1:0]              bkt_lvl_o,
   output logic [WIDTH_BIN_ID-1:0]           bkt_bin_o,
   output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_raddr_ls_o,
   input  logic [WIDTH_LVL_STATES-1:0]       ram_rdata_ls_i,
   output logic                              ram_we_ls_o,
   output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_waddr_ls_o,
   output logic [WIDTH_LVL_STATES-1:0]       ram_wdata_ls_o
);

   typedef enum logic [1:0] {IDLE, SCAN, MARK, DONE} state_t;

   state_t                  state, state_nxt;
   logic [WIDTH_LVL-1:0]    lvl_cnt;
   logic [WIDTH_LVL-1:0]    floor_q;
   logic                    mark_q;
   logic                    issue_act;
   logic [RD_LATENCY-1:0]   tag_vld;
   logic [WIDTH_LVL-1:0]    tag_lvl [RD_LATENCY];

   logic                    accept, rng_ok, issue, resp_vld, hit, miss_end, flush;
   logic [WIDTH_LVL-1:0]    resp_tag;
   logic [WIDTH_BIN_ID-1:0] resp_bin;

   assign accept   = (state == IDLE) && start_find;
   assign rng_ok   = (bkt_lvl_i >= lvl_floor_i);
   assign issue    = (state == SCAN) && issue_act && !abort_i;
   assign resp_vld = tag_vld[RD_LATENCY-1];
   assign resp_tag = tag_lvl[RD_LATENCY-1];
   assign resp_bin = ram_rdata_ls_i[WIDTH_LVL_STATES-1:1];
   assign hit      = (state == SCAN) && resp_vld && !ram_rdata_ls_i[0];
   // Responses return in issue order, so the floor tag is always the last one.
   assign miss_end = (state == SCAN) && resp_vld && ram_rdata_ls_i[0] && (resp_tag == floor_q);
   assign flush    = (state == SCAN) && (hit || miss_end || abort_i);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = rng_ok ? SCAN : MARK;
         SCAN: begin
            if (abort_i)              state_nxt = IDLE;
            else if (hit || miss_end) state_nxt = MARK;
         end
         MARK: state_nxt = abort_i ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_cnt   <= '0;
         floor_q   <= '0;
         mark_q    <= 1'b0;
         issue_act <= 1'b0;
         found_o   <= 1'b0;
         bkt_lvl_o <= '0;
         bkt_bin_o <= '0;
         tag_vld   <= '0;
         for (int i = 0; i < RD_LATENCY; i++) tag_lvl[i] <= '0;
      end else begin
         tag_vld[0] <= issue;
         tag_lvl[0] <= lvl_cnt;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_lvl[i] <= tag_lvl[i-1];
         end
         if (flush) tag_vld <= '0;

         if (accept) begin
            lvl_cnt   <= bkt_lvl_i;
            floor_q   <= lvl_floor_i;
            mark_q    <= mode_mark_i;
            issue_act <= rng_ok;
            found_o   <= 1'b0;
            bkt_lvl_o <= '0;
            bkt_bin_o <= '0;
         end else if ((state == SCAN || state == MARK) && abort_i) begin
            issue_act <= 1'b0;
            found_o   <= 1'b0;
            bkt_lvl_o <= '0;
            bkt_bin_o <= '0;
         end else if (hit) begin
            issue_act <= 1'b0;
            found_o   <= 1'b1;
            bkt_lvl_o <= resp_tag;
            bkt_bin_o <= resp_bin;
         end else if (issue) begin
            // Stop at the floor rather than decrementing past it.
            if (lvl_cnt == floor_q) issue_act <= 1'b0;
            else                    lvl_cnt   <= lvl_cnt - WIDTH_LVL'(1);
         end
      end
   end

   assign busy_o         = (state == SCAN) || (state == MARK);
   assign apply_find_o   = busy_o;
   assign done_find      = (state == DONE) && !rst;
   assign ram_raddr_ls_o = issue ? lvl_cnt[ADDR_WIDTH_LVLS_STATES-1:0] : '0;
   assign ram_we_ls_o    = (state == MARK) && mark_q && found_o && !abort_i && !rst;
   assign ram_waddr_ls_o = ram_we_ls_o ? bkt_lvl_o[ADDR_WIDTH_LVLS_STATES-1:0] : '0;
   assign ram_wdata_ls_o = ram_we_ls_o ? {bkt_bin_o, 1'b1} : '0;

endmodule
